// File: rtl/memory_row_copy_controller_pkg.sv
// Shared types and row geometry for the row copy controller.
package memory_row_copy_controller_pkg;

  localparam int unsigned ROW_WORDS  = 16;
  localparam int unsigned ROW_BITS   = 256;
  localparam int unsigned ROW_ADDR_W = 10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWait  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/arbiter_starve_counter.sv
// Counts consecutive cycles the engine's row write was deferred by the CPU on port B.
module arbiter_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic defer,
  input  logic clear,
  output logic limit_hit
);

  logic [7:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == 8'(STARVE_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (defer && !limit_hit) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_row_copy_controller.sv
// Row copy engine sharing the banked memory with the CPU; CPU port B wins until starvation.
module memory_row_copy_controller
  import memory_row_copy_controller_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ROW_ADDR_W-1:0] src_row,
  input  logic [ROW_ADDR_W-1:0] dst_row,
  input  logic [10:0]           row_count,
  output logic                  busy,
  output logic                  done,
  input  logic [13:0]           cpu_a_address,
  output logic                  cpu_a_stall,
  input  logic                  cpu_b_req,
  input  logic                  cpu_b_write,
  input  logic [13:0]           cpu_b_address,
  input  logic [15:0]           cpu_b_data,
  output logic                  cpu_b_grant,
  output logic [13:0]           mem_portA_address,
  output logic [13:0]           mem_portB_address,
  output logic                  mem_write_enable,
  output logic [15:0]           mem_data_in,
  output logic                  mem_row_write,
  output logic [ROW_BITS-1:0]   mem_row_data,
  input  logic [ROW_BITS-1:0]   mem_row_data_out
);

  localparam logic [2:0] WaitInit = 3'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [ROW_ADDR_W-1:0] src_q, src_d;
  logic [ROW_ADDR_W-1:0] dst_q, dst_d;
  logic [10:0]           remaining_q, remaining_d;
  logic [2:0]            wait_q, wait_d;
  logic [ROW_BITS-1:0]   row_buf_q, row_buf_d;
  logic                  engine_write;
  logic                  defer;
  logic                  limit_hit;

  arbiter_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .defer    (defer),
    .clear    (engine_write),
    .limit_hit(limit_hit)
  );

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
    wait_d       = wait_q;
    row_buf_d    = row_buf_q;
    engine_write = 1'b0;
    defer        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d       = src_row;
          dst_d       = dst_row;
          remaining_d = row_count;
          state_d     = (row_count == 11'd0) ? StDone : StRead;
        end
      end
      StRead: begin
        wait_d  = WaitInit;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == 3'd0) begin
          row_buf_d = mem_row_data_out;
          state_d   = StWrite;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      StWrite: begin
        // CPU keeps port B unless it is idle or has starved the engine long enough.
        if (!cpu_b_req || limit_hit) begin
          engine_write = 1'b1;
          src_d        = src_q + 10'd1;
          dst_d        = dst_q + 10'd1;
          remaining_d  = remaining_q - 11'd1;
          state_d      = (remaining_q == 11'd1) ? StDone : StRead;
        end else begin
          defer = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      row_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      row_buf_q   <= row_buf_d;
    end
  end

  always_comb begin
    busy              = (state_q != StIdle);
    done              = (state_q == StDone);
    cpu_a_stall       = (state_q == StRead);
    mem_portA_address = cpu_a_stall ? {src_q, 4'b0000} : cpu_a_address;
    cpu_b_grant       = cpu_b_req & ~engine_write;
    mem_portB_address = engine_write ? {dst_q, 4'b0000} : cpu_b_address;
    mem_write_enable  = cpu_b_req & cpu_b_write & ~engine_write;
    mem_data_in       = cpu_b_data;
    mem_row_write     = engine_write;
    mem_row_data      = row_buf_q;
  end

endmodule

// File: tb/tb_memory_row_copy_controller.sv
// Self-checking bench: memory model plus a row-level copy reference, directed and random copies.
module tb_memory_row_copy_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   src_row, dst_row;
  logic [10:0]  row_count;
  logic         busy, done;
  logic [13:0]  cpu_a_address;
  logic         cpu_a_stall;
  logic         cpu_b_req, cpu_b_write;
  logic [13:0]  cpu_b_address;
  logic [15:0]  cpu_b_data;
  logic         cpu_b_grant;
  logic [13:0]  mem_portA_address, mem_portB_address;
  logic         mem_write_enable;
  logic [15:0]  mem_data_in;
  logic         mem_row_write;
  logic [255:0] mem_row_data, mem_row_data_out;

  always #5 clock = ~clock;

  memory_row_copy_controller dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .src_row          (src_row),
    .dst_row          (dst_row),
    .row_count        (row_count),
    .busy             (busy),
    .done             (done),
    .cpu_a_address    (cpu_a_address),
    .cpu_a_stall      (cpu_a_stall),
    .cpu_b_req        (cpu_b_req),
    .cpu_b_write      (cpu_b_write),
    .cpu_b_address    (cpu_b_address),
    .cpu_b_data       (cpu_b_data),
    .cpu_b_grant      (cpu_b_grant),
    .mem_portA_address(mem_portA_address),
    .mem_portB_address(mem_portB_address),
    .mem_write_enable (mem_write_enable),
    .mem_data_in      (mem_data_in),
    .mem_row_write    (mem_row_write),
    .mem_row_data     (mem_row_data),
    .mem_row_data_out (mem_row_data_out)
  );

  // Banked memory model, read latency 1; preload port shares the single write process.
  logic [15:0]  mem [16384];
  logic [9:0]   rd_row_q = '0;
  logic         pre_we = 1'b0;
  logic [9:0]   pre_row = '0;
  logic [255:0] pre_data = '0;

  always @(posedge clock) begin
    rd_row_q <= mem_portA_address[13:4];
    if (pre_we) begin
      for (int w = 0; w < 16; w++) mem[{pre_row, 4'(w)}] <= pre_data[w*16 +: 16];
    end else begin
      if (mem_row_write)
        for (int w = 0; w < 16; w++) mem[{mem_portB_address[13:4], 4'(w)}] <= mem_row_data[w*16 +: 16];
      if (mem_write_enable) mem[mem_portB_address] <= mem_data_in;
    end
  end

  always_comb begin
    mem_row_data_out = '0;
    for (int w = 0; w < 16; w++) mem_row_data_out[w*16 +: 16] = mem[{rd_row_q, 4'(w)}];
  end

  // Reference state
  logic [15:0] exp_mem [16384];
  int n_vec = 0;
  int n_err = 0;

  int          rw_cyc[$];
  logic [9:0]  rw_dst[$];
  logic [9:0]  rd_src[$];
  logic        grant_q[$];
  int          done_cyc;
  logic        busy_after;
  logic        abort_busy, abort_stall, abort_done;
  logic        c1_stall, c1_grant, c1_we, c1_rw, c1_done;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int r, input int w);
    logic [9:0] rr;
    rr = 10'(r);
    return {rr[7:0], 2'b00, rr[9:8], 4'(w)};
  endfunction

  task automatic ref_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++)
      for (int w = 0; w < 16; w++)
        exp_mem[((d + i) % 1024) * 16 + w] = exp_mem[((s + i) % 1024) * 16 + w];
  endtask

  task automatic compare_all(input string tag);
    int nm = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== exp_mem[i]) nm++;
    check_eq(tag, 256'(nm), 256'd0);
  endtask

  // mode: 0 idle CPU, 1 CPU holds read request, 2 random CPU traffic,
  // 3 CPU write on the first busy cycle, 4 reset during row 2 wait.
  task automatic run_copy(input int s, input int d, input int n, input int mode, input int budget);
    logic        pend = 1'b0;
    logic        pw = 1'b0;
    logic [13:0] pa = '0;
    logic [15:0] pd = '0;
    rw_cyc.delete(); rw_dst.delete(); rd_src.delete(); grant_q.delete();
    done_cyc = -1;
    busy_after = 1'b1;
    src_row = 10'(s); dst_row = 10'(d); row_count = 11'(n); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (mode == 4 && cyc == 8) reset = 1'b1;
      if (mode == 4 && cyc == 9) begin
        reset = 1'b0;
        @(negedge clock);
        abort_busy = busy; abort_stall = cpu_a_stall; abort_done = done;
        break;
      end
      cpu_b_req = 1'b0; cpu_b_write = 1'b0;
      if (mode == 1) cpu_b_req = 1'b1;
      if (mode == 3 && cyc == 1) begin
        cpu_b_req = 1'b1; cpu_b_write = 1'b1; cpu_b_address = 14'h0123; cpu_b_data = 16'hBEEF;
      end
      if (mode == 2) begin
        if (!pend && $urandom_range(0, 1) == 1) begin
          pend = 1'b1;
          pw = 1'($urandom_range(0, 1));
          pa = {10'($urandom_range(768, 1023)), 4'($urandom_range(0, 15))};
          pd = 16'($urandom);
        end
        cpu_b_req = pend; cpu_b_write = pw; cpu_b_address = pa; cpu_b_data = pd;
      end
      cpu_a_address = 14'($urandom);
      @(negedge clock);
      grant_q.push_back(cpu_b_grant);
      if (cpu_a_stall) rd_src.push_back(mem_portA_address[13:4]);
      if (mem_row_write) begin
        rw_cyc.push_back(cyc);
        rw_dst.push_back(mem_portB_address[13:4]);
      end
      if (mode == 2 && mem_row_write)
        check_eq("row_write_excludes_cpu", {254'd0, cpu_b_grant, mem_write_enable}, 256'd0);
      if (mode == 3 && cyc == 1) begin
        c1_stall = cpu_a_stall; c1_grant = cpu_b_grant; c1_we = mem_write_enable;
        c1_rw = mem_row_write; c1_done = done;
      end
      if (mode == 2 && pend && cpu_b_grant) begin
        if (pw) exp_mem[pa] = pd;
        pend = 1'b0;
      end
      if (done) done_cyc = cyc;
      @(posedge clock); #1;
      if (done_cyc >= 0) begin
        cpu_b_req = 1'b0;
        @(negedge clock);
        busy_after = busy;
        break;
      end
    end
    cpu_b_req = 1'b0; cpu_b_write = 1'b0;
    if (mode != 4) check_eq("done_within_budget", 256'(done_cyc >= 0), 256'd1);
  endtask

  initial begin
    logic [255:0] row_v;
    logic [255:0] exp_v;
    int s, d, n, g_ones;
    reset = 1'b1; start = 1'b0; src_row = '0; dst_row = '0; row_count = '0;
    cpu_a_address = '0; cpu_b_req = 1'b0; cpu_b_write = 1'b0;
    cpu_b_address = '0; cpu_b_data = '0;

    for (int r = 0; r < 1024; r++) begin
      pre_we = 1'b1; pre_row = 10'(r);
      for (int w = 0; w < 16; w++) begin
        pre_data[w*16 +: 16] = pat(r, w);
        exp_mem[r * 16 + w] = pat(r, w);
      end
      @(posedge clock); #1;
    end
    pre_we = 1'b0;
    @(negedge clock);
    check_eq("reset_busy", 256'(busy), 256'd0);
    check_eq("reset_done", 256'(done), 256'd0);
    check_eq("reset_row_write", 256'(mem_row_write), 256'd0);
    check_eq("reset_a_stall", 256'(cpu_a_stall), 256'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single uncontended row
    run_copy(5, 9, 1, 0, 20);
    check_eq("one_row_writes", 256'(rw_cyc.size()), 256'd1);
    if (rw_cyc.size() > 0) check_eq("one_row_write_cycle", 256'(rw_cyc[0]), 256'd3);
    check_eq("one_row_done_cycle", 256'(done_cyc), 256'd4);
    check_eq("one_row_busy_after", 256'(busy_after), 256'd0);
    for (int w = 0; w < 16; w++) begin
      row_v[w*16 +: 16] = mem[9 * 16 + w];
      exp_v[w*16 +: 16] = 16'h0500 + 16'(w);
    end
    check_eq("row9_contents", row_v, exp_v);
    ref_copy(5, 9, 1);
    compare_all("mem_after_one_row");

    // Zero rows
    run_copy(7, 8, 0, 0, 10);
    check_eq("zero_done_cycle", 256'(done_cyc), 256'd1);
    check_eq("zero_writes", 256'(rw_cyc.size()), 256'd0);

    // Wrap at row 1023
    run_copy(1022, 1020, 4, 0, 30);
    check_eq("wrap_reads", 256'(rd_src.size()), 256'd4);
    check_eq("wrap_writes", 256'(rw_cyc.size()), 256'd4);
    for (int i = 0; i < 4 && i < rd_src.size(); i++)
      check_eq("wrap_src_row", 256'(rd_src[i]), 256'((1022 + i) % 1024));
    for (int i = 0; i < 4 && i < rw_dst.size(); i++)
      check_eq("wrap_dst_row", 256'(rw_dst[i]), 256'(1020 + i));
    check_eq("wrap_done_cycle", 256'(done_cyc), 256'd13);
    ref_copy(1022, 1020, 4);
    compare_all("mem_after_wrap");

    // Starvation bound: CPU read request held the whole time
    run_copy(30, 31, 1, 1, 40);
    check_eq("starve_writes", 256'(rw_cyc.size()), 256'd1);
    if (rw_cyc.size() > 0) check_eq("starve_write_cycle", 256'(rw_cyc[0]), 256'd11);
    g_ones = 0;
    for (int c = 3; c <= 10 && c <= grant_q.size(); c++) if (grant_q[c-1]) g_ones++;
    check_eq("starve_cpu_grants", 256'(g_ones), 256'd8);
    if (grant_q.size() >= 12) begin
      check_eq("starve_grant_on_write", 256'(grant_q[10]), 256'd0);
      check_eq("starve_grant_after", 256'(grant_q[11]), 256'd1);
    end
    ref_copy(30, 31, 1);
    compare_all("mem_after_starve");

    // CPU word write during engine READ
    run_copy(20, 21, 1, 3, 20);
    check_eq("read_cycle_signals", {251'd0, c1_stall, c1_grant, c1_we, c1_rw, c1_done},
             {251'd0, 5'b11100});
    check_eq("cpu_word_landed", 256'(mem[14'h0123]), 256'hBEEF);
    exp_mem[14'h0123] = 16'hBEEF;
    ref_copy(20, 21, 1);
    compare_all("mem_after_cpu_write");

    // Reset during row 2 wait, then a fresh copy
    run_copy(100, 200, 4, 4, 20);
    check_eq("abort_idle_signals", {253'd0, abort_busy, abort_stall, abort_done}, 256'd0);
    check_eq("abort_writes", 256'(rw_cyc.size()), 256'd2);
    ref_copy(100, 200, 2);
    compare_all("mem_after_abort");
    run_copy(300, 310, 2, 0, 20);
    check_eq("restart_done_cycle", 256'(done_cyc), 256'd7);
    check_eq("restart_writes", 256'(rw_cyc.size()), 256'd2);
    ref_copy(300, 310, 2);
    compare_all("mem_after_restart");

    // Random copies under random CPU traffic confined to rows 768..1023
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, 500);
      d = $urandom_range(0, 500);
      n = $urandom_range(1, 6);
      run_copy(s, d, n, 2, 1 + n * 12 + 5);
      check_eq("rand_writes", 256'(rw_cyc.size()), 256'(n));
      for (int i = 0; i < rw_dst.size() && i < n; i++)
        check_eq("rand_dst_row", 256'(rw_dst[i]), 256'((d + i) % 1024));
      ref_copy(s, d, n);
      compare_all("mem_after_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

endmodule
